// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: widths, opcode constants and the
// controller state encoding. Opcode constants are shared with the ALU.
package cpu_pkg;

    localparam int CPU_DATA_W  = 8;
    localparam int CPU_ADDR_W  = 8;
    localparam int ALU_OP_W    = 3;
    localparam int REG_IDX_W   = 2;
    localparam int OP_W        = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_AND = 3'b001;
    localparam logic [OP_W-1:0] OP_NOT = 3'b010;
    localparam logic [OP_W-1:0] OP_LDI = 3'b011;
    localparam logic [OP_W-1:0] OP_JZ  = 3'b100;
    localparam logic [OP_W-1:0] OP_JMP = 3'b101;
    localparam logic [OP_W-1:0] OP_NOP = 3'b110;
    localparam logic [OP_W-1:0] OP_HLT = 3'b111;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_LOAD_IR = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_IMM_RD  = 3'd4,
        ST_IMM_USE = 3'd5,
        ST_HALT    = 3'd6
    } state_e;

    // Opcode field of an instruction byte: [7:5] op, [4:3] rd, [2:1] rs, [0] unused.
    function automatic logic [OP_W-1:0] ir_op(input logic [CPU_DATA_W-1:0] ir);
        return ir[7:5];
    endfunction

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decoder: splits the IR into fields and classifies
// the opcode into ALU / two-byte immediate / halt groups.
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [CPU_DATA_W-1:0] ir_i,
    output logic                  is_alu_o,
    output logic                  is_imm_o,
    output logic                  is_halt_o,
    output logic [REG_IDX_W-1:0]  rd_o,
    output logic [REG_IDX_W-1:0]  rs_o,
    output logic [ALU_OP_W-1:0]   alu_opcode_o,
    output logic [OP_W-1:0]       op_o
);

    logic unused_s;

    assign op_o     = ir_op(ir_i);
    assign rd_o     = ir_i[4:3];
    assign rs_o     = ir_i[2:1];
    assign unused_s = ir_i[0];

    // Classify the opcode; reserved 110 falls out as none of the groups (NOP).
    always_comb begin
        is_alu_o     = 1'b0;
        is_imm_o     = 1'b0;
        is_halt_o    = 1'b0;
        alu_opcode_o = OP_ADD;
        case (op_o)
            OP_ADD, OP_AND, OP_NOT: begin
                is_alu_o     = 1'b1;
                alu_opcode_o = op_o;
            end
            OP_LDI, OP_JZ, OP_JMP: begin
                is_imm_o = 1'b1;
            end
            OP_HLT: begin
                is_halt_o = 1'b1;
            end
            default: begin
                is_alu_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute controller. Owns PC, IR and the latched
// ALU flags; outputs are decoded from the current state and IR only, except
// the FETCH read strobe which follows the run enable in the same cycle.
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int                DATA_W   = CPU_DATA_W,
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_rd_en,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic [ALU_OP_W-1:0]  alu_opcode,
    input  logic                 alu_zero,
    input  logic                 alu_ovf,
    output logic [REG_IDX_W-1:0] rf_raddr_a,
    output logic [REG_IDX_W-1:0] rf_raddr_b,
    output logic [REG_IDX_W-1:0] rf_waddr,
    output logic                 rf_we,
    output logic                 rf_wsel,
    output logic [DATA_W-1:0]    imm,
    output logic                 zero_q,
    output logic                 ovf_q,
    output logic [ADDR_W-1:0]    pc,
    output logic                 halted
);

    localparam logic [ADDR_W-1:0] PC_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic [DATA_W-1:0]     ir_q, ir_d;
    logic                  zero_d, ovf_d;

    logic                  is_alu_s, is_imm_s, is_halt_s;
    logic [REG_IDX_W-1:0]  rd_s, rs_s;
    logic [ALU_OP_W-1:0]   dec_alu_op_s;
    logic [OP_W-1:0]       op_s;
    logic                  rd_en_s, we_s;

    cpu_decode u_decode (
        .ir_i         (ir_q),
        .is_alu_o     (is_alu_s),
        .is_imm_o     (is_imm_s),
        .is_halt_o    (is_halt_s),
        .rd_o         (rd_s),
        .rs_o         (rs_s),
        .alu_opcode_o (dec_alu_op_s),
        .op_o         (op_s)
    );

    // Next-state, PC, IR and flag update logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_FETCH: begin
                if (en) begin
                    state_d = ST_LOAD_IR;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_LOAD_IR: begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + PC_INC;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_halt_s) begin
                    state_d = ST_HALT;
                end else if (is_alu_s) begin
                    state_d = ST_EXEC;
                end else if (is_imm_s) begin
                    state_d = ST_IMM_RD;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                zero_d  = alu_zero;
                ovf_d   = alu_ovf;
                state_d = ST_FETCH;
            end
            ST_IMM_RD: begin
                state_d = ST_IMM_USE;
            end
            ST_IMM_USE: begin
                state_d = ST_FETCH;
                case (op_s)
                    OP_LDI: pc_d = pc_q + PC_INC;
                    OP_JMP: pc_d = ADDR_W'(mem_rdata);
                    OP_JZ: begin
                        if (zero_q) begin
                            pc_d = ADDR_W'(mem_rdata);
                        end else begin
                            pc_d = pc_q + PC_INC;
                        end
                    end
                    default: pc_d = pc_q;
                endcase
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Controller state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= {DATA_W{1'b0}};
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    // Moore output decode from state and IR; idle values everywhere else.
    always_comb begin
        rd_en_s    = 1'b0;
        we_s       = 1'b0;
        rf_wsel    = 1'b0;
        rf_waddr   = {REG_IDX_W{1'b0}};
        rf_raddr_a = {REG_IDX_W{1'b0}};
        rf_raddr_b = {REG_IDX_W{1'b0}};
        alu_opcode = OP_ADD;
        imm        = {DATA_W{1'b0}};
        case (state_q)
            ST_FETCH: begin
                rd_en_s = en;
            end
            ST_EXEC: begin
                alu_opcode = dec_alu_op_s;
                if (op_s == OP_NOT) begin
                    rf_raddr_a = rs_s;
                end else begin
                    rf_raddr_a = rd_s;
                end
                rf_raddr_b = rs_s;
                rf_waddr   = rd_s;
                we_s       = 1'b1;
            end
            ST_IMM_RD: begin
                rd_en_s = 1'b1;
            end
            ST_IMM_USE: begin
                imm = mem_rdata;
                if (op_s == OP_LDI) begin
                    we_s     = 1'b1;
                    rf_wsel  = 1'b1;
                    rf_waddr = rd_s;
                end else begin
                    we_s = 1'b0;
                end
            end
            default: begin
                rd_en_s = 1'b0;
            end
        endcase
    end

    // Strobes are killed combinationally while reset is asserted.
    assign mem_rd_en = rd_en_s & rst_n;
    assign rf_we     = we_s & rst_n;
    assign mem_addr  = pc_q;
    assign pc        = pc_q;
    assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench: instruction-level reference model expands each
// instruction into its expected per-cycle outputs, compared every cycle.
module tb_cpu_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata = 8'h00;
    logic [2:0] alu_opcode;
    logic       alu_zero, alu_ovf;
    logic [1:0] rf_raddr_a, rf_raddr_b, rf_waddr;
    logic       rf_we, rf_wsel;
    logic [7:0] imm;
    logic       zero_q, ovf_q;
    logic [7:0] pc;
    logic       halted;

    cpu_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .alu_opcode(alu_opcode), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_waddr(rf_waddr),
        .rf_we(rf_we), .rf_wsel(rf_wsel), .imm(imm),
        .zero_q(zero_q), .ovf_q(ovf_q), .pc(pc), .halted(halted)
    );

    initial forever #5 clk = ~clk;

    // ALU behaviour: returns {zero, ovf, result}.
    function automatic logic [9:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic       o;
        case (op)
            3'd0: begin r = a + b; o = (a[7] == b[7]) && (r[7] != a[7]); end
            3'd1: begin r = a & b; o = 1'b0; end
            3'd2: begin r = ~a;    o = 1'b0; end
            default: begin r = 8'h00; o = 1'b0; end
        endcase
        return {(r == 8'h00), o, r};
    endfunction

    // Environment: synchronous program memory, register file and ALU.
    logic [7:0] mem [256];
    logic [7:0] rf_env [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [9:0] alu_out;

    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];
    always @(posedge clk) if (rf_we) rf_env[rf_waddr] <= rf_wsel ? imm : alu_out[7:0];
    always_comb alu_out = alu_f(alu_opcode, rf_env[rf_raddr_a], rf_env[rf_raddr_b]);
    assign alu_zero = alu_out[9];
    assign alu_ovf  = alu_out[8];

    // Reference model state.
    typedef struct {
        logic       rd_en;  logic [7:0] addr;
        logic       we;     logic       wsel;  logic [1:0] waddr;
        logic [1:0] ra;     logic [1:0] rb;    logic [2:0] aop;
        logic [7:0] imm;    logic       halted; logic [7:0] pc;
        logic       z;      logic       o;
        logic       c_wr;   logic [1:0] c_idx; logic [7:0] c_val;
        logic       c_flags; logic      c_z;   logic       c_o;
        logic       c_pc;   logic [7:0] c_pcv; logic       c_halt;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mpc = 8'h00;
    logic       mz = 1'b0, mo = 1'b0, mhalt = 1'b0;
    logic [7:0] mregs [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    int         en_off = 0;
    int         n_vec = 0, n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic exp_t idle_rec(input logic [7:0] p);
        exp_t r;
        r = '{default: '0};
        r.pc = p; r.addr = p; r.z = mz; r.o = mo;
        return r;
    endfunction

    // Expand the instruction at the model PC into its per-cycle expectations.
    task automatic gen_instr();
        exp_t       r;
        logic [7:0] ir, p1, iv;
        logic [2:0] op;
        logic [1:0] rd, rs, ra;
        logic [9:0] a;
        ir = mem[mpc]; op = ir[7:5]; rd = ir[4:3]; rs = ir[2:1];
        p1 = mpc + 8'd1; iv = mem[p1];
        r = idle_rec(mpc); r.rd_en = 1'b1; q.push_back(r);
        r = idle_rec(mpc); q.push_back(r);
        r = idle_rec(p1); r.c_pc = 1'b1; r.c_pcv = p1;
        if (op == 3'd7) r.c_halt = 1'b1;
        if (op <= 3'd2) r.c_pc = 1'b0;
        if (op >= 3'd3 && op <= 3'd5) r.c_pc = 1'b0;
        q.push_back(r);
        if (op <= 3'd2) begin
            ra = (op == 3'd2) ? rs : rd;
            a = alu_f(op, mregs[ra], mregs[rs]);
            r = idle_rec(p1);
            r.aop = op; r.ra = ra; r.rb = rs; r.we = 1'b1; r.waddr = rd;
            r.c_wr = 1'b1; r.c_idx = rd; r.c_val = a[7:0];
            r.c_flags = 1'b1; r.c_z = a[9]; r.c_o = a[8];
            r.c_pc = 1'b1; r.c_pcv = p1;
            q.push_back(r);
        end else if (op <= 3'd5) begin
            r = idle_rec(p1); r.rd_en = 1'b1; q.push_back(r);
            r = idle_rec(p1); r.imm = iv; r.c_pc = 1'b1;
            if (op == 3'd3) begin
                r.we = 1'b1; r.wsel = 1'b1; r.waddr = rd;
                r.c_wr = 1'b1; r.c_idx = rd; r.c_val = iv; r.c_pcv = p1 + 8'd1;
            end else if (op == 3'd5) begin
                r.c_pcv = iv;
            end else begin
                r.c_pcv = mz ? iv : p1 + 8'd1;
            end
            q.push_back(r);
        end
    endtask

    task automatic retire(input exp_t r);
        if (r.c_wr) mregs[r.c_idx] = r.c_val;
        if (r.c_flags) begin mz = r.c_z; mo = r.c_o; end
        if (r.c_pc) mpc = r.c_pcv;
        if (r.c_halt) mhalt = 1'b1;
    endtask

    // Run n cycles starting at a falling edge; compare outputs mid-low-phase.
    task automatic run_cycles(input int n);
        exp_t cur;
        logic slot;
        for (int c = 0; c < n; c++) begin
            slot = (q.size() == 0);
            if (en_off > 0) begin en = 1'b0; en_off--; end
            else if (slot) en = ($urandom_range(99) < 80);
            else en = 1'($urandom_range(1));
            if (slot) begin
                if (mhalt) begin cur = idle_rec(mpc); cur.halted = 1'b1; q.push_back(cur); end
                else if (en) gen_instr();
                else q.push_back(idle_rec(mpc));
            end
            cur = q.pop_front();
            #1;
            check_eq("mem_rd_en", 32'(mem_rd_en), 32'(cur.rd_en));
            if (cur.rd_en) check_eq("mem_addr", 32'(mem_addr), 32'(cur.addr));
            check_eq("rf_we", 32'(rf_we), 32'(cur.we));
            check_eq("rf_wsel", 32'(rf_wsel), 32'(cur.wsel));
            check_eq("rf_waddr", 32'(rf_waddr), 32'(cur.waddr));
            check_eq("rf_raddr_a", 32'(rf_raddr_a), 32'(cur.ra));
            check_eq("rf_raddr_b", 32'(rf_raddr_b), 32'(cur.rb));
            check_eq("alu_opcode", 32'(alu_opcode), 32'(cur.aop));
            check_eq("imm", 32'(imm), 32'(cur.imm));
            check_eq("halted", 32'(halted), 32'(cur.halted));
            check_eq("pc", 32'(pc), 32'(cur.pc));
            check_eq("zero_q", 32'(zero_q), 32'(cur.z));
            check_eq("ovf_q", 32'(ovf_q), 32'(cur.o));
            @(posedge clk);
            retire(cur);
            @(negedge clk);
        end
    endtask

    // Assert reset away from any clock edge, check its immediate effect, release on a falling edge.
    task automatic apply_reset();
        #2;
        en = 1'b1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_pc", 32'(pc), 32'h0);
        check_eq("rst_halted", 32'(halted), 32'h0);
        check_eq("rst_mem_rd_en", 32'(mem_rd_en), 32'h0);
        check_eq("rst_rf_we", 32'(rf_we), 32'h0);
        check_eq("rst_zero_q", 32'(zero_q), 32'h0);
        check_eq("rst_ovf_q", 32'(ovf_q), 32'h0);
        q.delete();
        mpc = 8'h00; mz = 1'b0; mo = 1'b0; mhalt = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fill_nop();
        for (int a = 0; a < 256; a++) mem[a] = 8'hC0;
    endtask

    initial begin
        logic [7:0] b;
        // Program: LDI r1,7F; LDI r2,01; ADD r1,r2 (ovf); LDI r3,FF; LDI r0,01;
        // ADD r3,r0 (zero); JZ 40 (taken); @40 ADD r1,r2; JZ 20 (not taken); NOP; HLT.
        fill_nop();
        mem[8'h00] = 8'h68; mem[8'h01] = 8'h7F; mem[8'h02] = 8'h70; mem[8'h03] = 8'h01;
        mem[8'h04] = 8'h0C; mem[8'h05] = 8'h78; mem[8'h06] = 8'hFF; mem[8'h07] = 8'h60;
        mem[8'h08] = 8'h01; mem[8'h09] = 8'h18; mem[8'h0A] = 8'h80; mem[8'h0B] = 8'h40;
        mem[8'h40] = 8'h0C; mem[8'h41] = 8'h80; mem[8'h42] = 8'h20;
        mem[8'h43] = 8'hC0; mem[8'h44] = 8'hE0;
        apply_reset();
        en_off = 5;
        run_cycles(110);
        // Wrap: JMP FF, then JMP at FF whose immediate comes from address 00.
        fill_nop();
        mem[8'h00] = 8'h10; mem[8'h01] = 8'hA0; mem[8'h02] = 8'hFF;
        mem[8'hFF] = 8'hA0; mem[8'h10] = 8'hE0;
        apply_reset();
        run_cycles(40);
        // Random programs with resets landing mid-instruction.
        for (int e = 0; e < 20; e++) begin
            for (int a = 0; a < 256; a++) begin
                b = 8'($urandom_range(255));
                if (b[7:5] == 3'b111 && $urandom_range(3) != 0) b = 8'h00;
                mem[a] = b;
            end
            apply_reset();
            run_cycles(int'($urandom_range(200, 50)));
        end
        apply_reset();
        run_cycles(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
Multi-cycle fetch/decode/execute controller for the 8-bit CPU. It sits directly upstream of the ALU.
- Owns PC, IR and the latched flag register.
- Fetches instruction bytes from synchronous program memory.
- Drives the ALU opcode and register-file read/write controls.
- Captures the ALU zero/overflow outputs into flags used by conditional jumps.

Parameters:
DATA_W, 8, datapath/instruction width (fixed 8; parameter exists for package consistency)
ADDR_W, 8, program-memory address / PC width
RESET_PC, 8'h00, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable, sampled only in FETCH
mem_addr  out  ADDR_W  program memory address
mem_rd_en  out  1  read strobe; data valid on mem_rdata next cycle
mem_rdata  in  DATA_W  program memory read data
alu_opcode  out  3  to ALU opcode (000 ADD, 001 AND, 010 NOT)
alu_zero  in  1  ALU zero_flag
alu_ovf  in  1  ALU overflow_flag
rf_raddr_a  out  2  register-file port A index (feeds ALU a)
rf_raddr_b  out  2  register-file port B index (feeds ALU b)
rf_waddr  out  2  write index
rf_we  out  1  register-file write enable
rf_wsel  out  1  write-data select: 0 = ALU res, 1 = imm
imm  out  DATA_W  immediate byte for LDI
zero_q  out  1  latched zero flag
ovf_q  out  1  latched overflow flag
pc  out  ADDR_W  current PC
halted  out  1  high in HALT state

Behaviour:
- Instruction format: [7:5] op, [4:3] rd, [2:1] rs, [0] ignored.
- Op encodings:
  - 000 ADD, 001 AND, 010 NOT (rd = ~rs)
  - 011 LDI rd,#imm; 100 JZ #addr; 101 JMP #addr (all two-byte)
  - 110 reserved = NOP
  - 111 HLT
- Reset (async, rst_n low): state=FETCH, pc=RESET_PC, ir=0, zero_q=ovf_q=0, halted=0.
  - All strobes (mem_rd_en, rf_we) are forced 0 while rst_n is low.
  - Reset mid-instruction abandons it with no write issued.
- Memory: address and mem_rd_en presented in cycle N; mem_rdata sampled in cycle N+1.
- FETCH:
  - If en: mem_addr=pc, mem_rd_en=1, go to LOAD_IR.
  - Else: no read, stay in FETCH.
- LOAD_IR: ir<=mem_rdata; pc<=pc+1 (mod 2^ADDR_W). Go to DECODE.
- DECODE, by op:
  - ALU ops -> EXEC.
  - LDI/JZ/JMP -> IMM_RD.
  - HLT -> HALT.
  - 110 -> FETCH, with no side effects.
- EXEC:
  - alu_opcode=op; rf_raddr_a=rd, except NOT, which uses rf_raddr_a=rs; rf_raddr_b=rs.
  - rf_we=1, rf_wsel=0, rf_waddr=rd.
  - zero_q<=alu_zero, ovf_q<=alu_ovf. Go to FETCH.
  - ALU and register-file reads are combinational within the same cycle.
- IMM_RD: mem_addr=pc, mem_rd_en=1. Go to IMM_USE.
- IMM_USE: imm=mem_rdata. Go to FETCH. Per op:
  - LDI: rf_we=1, rf_wsel=1, rf_waddr=rd; pc<=pc+1.
  - JMP: pc<=mem_rdata.
  - JZ: pc<=mem_rdata if zero_q, else pc+1.
  - Flags are unchanged by LDI/JZ/JMP.
- HALT: halted=1, no strobes. Leaves only via reset.
- Latency: ALU op 4 cycles; LDI/JZ/JMP 5 cycles; NOP 3 cycles; HLT reaches HALT 3 cycles after FETCH.
- PC wraps 0xFF->0x00. An immediate for an opcode at 0xFF is read from 0x00.
- Idle defaults: alu_opcode=000, rf_* addresses 0, imm=0. Outputs are Moore, decoded from state/ir.

Decomposition:
- Shared package cpu_pkg holds:
  - op constants OP_ADD..OP_HLT (shared with alu);
  - ALU opcode width 3, DATA_W, register-index width 2;
  - FSM state encodings (FETCH, LOAD_IR, DECODE, EXEC, IMM_RD, IMM_USE, HALT).
- One sub-module, cpu_decode: combinational ir -> is_alu, is_imm, is_halt, rd, rs, alu_opcode.

Test Plan:
- Reset, en=1, mem[0..1]=68,7F:
  - cycle 0: mem_rd_en=1, mem_addr=00.
  - cycle 4: rf_we=1, rf_wsel=1, rf_waddr=1, imm=7F.
  - afterwards pc=02.
- Program 68,7F,70,01,0C (r1=7F, r2=01, ADD r1,r2); in the ADD EXEC cycle:
  - alu_opcode=000, rf_raddr_a=1, rf_raddr_b=2, rf_waddr=1, rf_we=1.
  - Model ALU returns 80/ovf=1, so next cycle ovf_q=1, zero_q=0.
- Set zero_q=1 via ADD FF+01, then JZ 80,40: pc=40 after IMM_USE.
  - Repeat with zero_q=0: pc = JZ address+2.
- pc=FF, mem[FF]=A0 (JMP), mem[00]=10:
  - immediate read at mem_addr=00.
  - pc=10 next.
- mem=C0 (NOP): 3 cycles, no rf_we, pc+1. Then E0 (HLT):
  - halted=1, no mem_rd_en for 20 cycles.
  - Assert rst_n low mid-cycle: halted=0 and pc=00 immediately, without a clock edge.
- Hold en=0 after reset for 5 cycles: mem_rd_en=0, pc=00.
  - Raise en: fetch begins the same cycle.
  - Drop en during DECODE: instruction still completes.
